// File: rtl/music_track_sequencer.sv
// Fixed-priority music track scheduler: arbitrates track requests onto one
// note-event ROM and one playnote channel, pacing events with a tempo tick enable.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; grant the highest-priority pending track
// FETCH   | rom_addr presented, waiting for the synchronous ROM
// LOAD    | rom_q valid: latch note/enable/delay, bump the event offset
// WAIT    | count tempo ticks until the event's delay has elapsed
// ADVANCE | step to the next event, or to END after the last one
// END     | done pulse, note off; loop back to base or release the channel
module music_track_sequencer #(
  parameter int NUM_TRACKS  = 3,
  parameter int ADDR_BITS   = 10,
  parameter int NOTE_BITS   = 7,
  parameter int DELAY_BITS  = 12,
  parameter int NOTE_OFFSET = 0,
  localparam int TRACK_BITS = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int ROM_BITS   = 1 + NOTE_BITS + DELAY_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic [NUM_TRACKS-1:0]           req,
  input  logic [NUM_TRACKS-1:0]           loop_mask,
  input  logic [NUM_TRACKS*ADDR_BITS-1:0] track_base,
  input  logic [NUM_TRACKS*ADDR_BITS-1:0] track_len,
  output logic [ADDR_BITS-1:0]            rom_addr,
  input  logic [ROM_BITS-1:0]             rom_q,
  output logic [NOTE_BITS-1:0]            note_out,
  output logic                            note_on_out,
  output logic                            active_valid,
  output logic [TRACK_BITS-1:0]           active_track,
  output logic                            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_ADVANCE,
    S_END
  } state_t;

  state_t state, state_n;

  logic [ADDR_BITS-1:0]  rom_addr_n;
  logic [NOTE_BITS-1:0]  note_n;
  logic                  note_on_n;
  logic                  valid_n;
  logic [TRACK_BITS-1:0] track_n;
  logic                  done_n;
  logic [ADDR_BITS-1:0]  offset, offset_n;
  logic [DELAY_BITS-1:0] delay_cnt, delay_cnt_n;
  logic [DELAY_BITS-1:0] delay_tgt, delay_tgt_n;
  logic [NUM_TRACKS-1:0] spent, spent_n;

  logic [ADDR_BITS-1:0] base_arr [NUM_TRACKS];
  logic [ADDR_BITS-1:0] len_arr  [NUM_TRACKS];

  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_unpack
    assign base_arr[g] = track_base[g*ADDR_BITS +: ADDR_BITS];
    assign len_arr[g]  = track_len[g*ADDR_BITS +: ADDR_BITS];
  end

  logic                  q_on;
  logic [NOTE_BITS-1:0]  q_note;
  logic [DELAY_BITS-1:0] q_delay;

  assign q_on    = rom_q[ROM_BITS-1];
  assign q_note  = rom_q[DELAY_BITS +: NOTE_BITS];
  assign q_delay = rom_q[DELAY_BITS-1:0];

  // Ascending scan: the last qualifying index, i.e. the highest priority, wins.
  logic                  win_valid;
  logic [TRACK_BITS-1:0] win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (req[i] && !spent[i]) begin
        win_valid = 1'b1;
        win_idx   = TRACK_BITS'(i);
      end
    end
  end

  logic [ADDR_BITS-1:0]  act_base, act_len, win_base, win_len;
  logic [DELAY_BITS-1:0] cnt_inc;
  logic                  preempt;

  assign act_base = base_arr[active_track];
  assign act_len  = len_arr[active_track];
  assign win_base = base_arr[win_idx];
  assign win_len  = len_arr[win_idx];
  assign cnt_inc  = delay_cnt + DELAY_BITS'(1);
  assign preempt  = !win_valid || (win_idx != active_track);

  always_comb begin
    state_n     = state;
    rom_addr_n  = rom_addr;
    note_n      = note_out;
    note_on_n   = note_on_out;
    valid_n     = active_valid;
    track_n     = active_track;
    offset_n    = offset;
    delay_cnt_n = delay_cnt;
    delay_tgt_n = delay_tgt;
    spent_n     = spent;

    // END is never interrupted so a finishing track always reports done.
    if ((state inside {S_FETCH, S_LOAD, S_WAIT, S_ADVANCE}) && preempt) begin
      state_n   = S_IDLE;
      note_on_n = 1'b0;
      valid_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            track_n    = win_idx;
            valid_n    = 1'b1;
            offset_n   = '0;
            rom_addr_n = win_base;
            state_n    = (win_len == '0) ? S_END : S_FETCH;
          end
        end
        S_FETCH: state_n = S_LOAD;
        S_LOAD: begin
          note_n      = q_note + NOTE_BITS'(NOTE_OFFSET);
          note_on_n   = q_on;
          delay_cnt_n = '0;
          delay_tgt_n = q_delay;
          offset_n    = offset + ADDR_BITS'(1);
          state_n     = (q_delay == '0) ? S_ADVANCE : S_WAIT;
        end
        S_WAIT: begin
          if (tick) begin
            delay_cnt_n = cnt_inc;
            if (cnt_inc == delay_tgt) state_n = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (offset == act_len) begin
            state_n = S_END;
          end else begin
            rom_addr_n = act_base + offset;
            state_n    = S_FETCH;
          end
        end
        S_END: begin
          if (loop_mask[active_track]) begin
            offset_n   = '0;
            rom_addr_n = act_base;
            state_n    = S_FETCH;
          end else begin
            spent_n[active_track] = 1'b1;
            valid_n               = 1'b0;
            state_n               = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Entering END silences the channel for the END cycle itself.
    if (state_n == S_END) note_on_n = 1'b0;
    done_n = (state_n == S_END);

    // A dropped request re-arms its track, overriding a same-cycle spent set.
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (!req[i]) spent_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rom_addr     <= '0;
      note_out     <= '0;
      note_on_out  <= 1'b0;
      active_valid <= 1'b0;
      active_track <= '0;
      done         <= 1'b0;
      offset       <= '0;
      delay_cnt    <= '0;
      delay_tgt    <= '0;
      spent        <= '0;
    end else begin
      state        <= state_n;
      rom_addr     <= rom_addr_n;
      note_out     <= note_n;
      note_on_out  <= note_on_n;
      active_valid <= valid_n;
      active_track <= track_n;
      done         <= done_n;
      offset       <= offset_n;
      delay_cnt    <= delay_cnt_n;
      delay_tgt    <= delay_tgt_n;
      spent        <= spent_n;
    end
  end

endmodule
